// File: rtl/drum_pkg.sv
// Shared drum-voice definitions for the sample ROM arbiter: voice indices,
// pipeline tag type and a request-contention helper.
package drum_pkg;

    localparam int NUM_VOICES = 4;

    typedef logic [1:0] voice_t;

    localparam voice_t KICK  = 2'd0;
    localparam voice_t SNARE = 2'd1;
    localparam voice_t HAT   = 2'd2;
    localparam voice_t CLAP  = 2'd3;

    typedef struct packed {
        logic   vld;
        voice_t voice;
    } tag_t;

    // True when two or more voices request in the same cycle.
    function automatic logic multi_req(input logic [NUM_VOICES-1:0] r);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NUM_VOICES; i++) begin
            n += 32'(r[i]);
        end
        return n >= 2;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection over the four drum voices; the priority pointer
// moves one past the winner at the end of every grant cycle.
module rr_arbiter
    import drum_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [NUM_VOICES-1:0] req,
    output logic [NUM_VOICES-1:0] gnt,
    output voice_t                gnt_idx,
    output logic                  gnt_vld
);

    voice_t ptr_q, ptr_d;
    voice_t cand;

    // NOTE: every output of this block gets a default first so no path leaves a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = ptr_q;
        gnt_vld = 1'b0;
        ptr_d   = ptr_q;
        cand    = ptr_q;
        if (en) begin
            // Walk from the farthest offset back to ptr so the nearest requester wins.
            for (int i = NUM_VOICES - 1; i >= 0; i--) begin
                cand = ptr_q + voice_t'(i);
                if (req[cand]) begin
                    gnt_idx = cand;
                    gnt_vld = 1'b1;
                end
            end
        end
        if (gnt_vld) begin
            gnt[gnt_idx] = 1'b1;
            ptr_d        = gnt_idx + voice_t'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr_q <= KICK;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/sample_rom_arbiter.sv
// Four-voice sample ROM arbiter: registered ROM request, tag pipeline matched to
// ROM latency, registered return. Contention counter built only with SAMPLE_ROM_ARB_STATS_EN.
module sample_rom_arbiter
    import drum_pkg::*;
#(
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 8,
    parameter int ROM_LAT = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic [NUM_VOICES-1:0]        req,
    input  logic [NUM_VOICES*ADDR_W-1:0] addr,
    output logic [NUM_VOICES-1:0]        gnt,
    output logic                         rom_rd,
    output logic [ADDR_W-1:0]            rom_addr,
    input  logic [DATA_W-1:0]            rom_data,
    output logic [NUM_VOICES-1:0]        rd_valid,
    output logic [DATA_W-1:0]            rd_data,
    output logic [15:0]                  conflict_cnt
);

    voice_t gnt_idx;
    logic   gnt_vld;

    rr_arbiter u_rr_arbiter (
        .clk     (clk),
        .reset   (reset),
        .en      (en),
        .req     (req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    logic                  rom_rd_q,   rom_rd_d;
    logic [ADDR_W-1:0]     rom_addr_q, rom_addr_d;
    logic [NUM_VOICES-1:0] rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]     rd_data_q,  rd_data_d;
    tag_t                  tag_q [0:ROM_LAT];
    tag_t                  tag_d [0:ROM_LAT];

    always_comb begin
        rom_rd_d   = gnt_vld;
        rom_addr_d = rom_addr_q;
        if (gnt_vld) begin
            rom_addr_d = addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
        end

        // Stage 0 lines up with rom_rd; the last stage lines up with rom_data.
        tag_d[0] = '{vld: gnt_vld, voice: gnt_idx};
        for (int k = 1; k <= ROM_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end

        rd_valid_d = '0;
        rd_data_d  = rd_data_q;
        if (tag_q[ROM_LAT].vld) begin
            rd_valid_d[tag_q[ROM_LAT].voice] = 1'b1;
            rd_data_d                        = rom_data;
        end
    end

    // NOTE: the tag pipeline is reset too, so reads in flight at reset never return.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rom_rd_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_valid_q <= '0;
            rd_data_q  <= '0;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            rom_rd_q   <= rom_rd_d;
            rom_addr_q <= rom_addr_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            for (int k = 0; k <= ROM_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign rom_rd   = rom_rd_q;
    assign rom_addr = rom_addr_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;

`ifdef SAMPLE_ROM_ARB_STATS_EN
    logic [15:0] conflict_cnt_q, conflict_cnt_d;

    always_comb begin
        conflict_cnt_d = conflict_cnt_q;
        if (en && multi_req(req) && (conflict_cnt_q != 16'hFFFF)) begin
            conflict_cnt_d = conflict_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            conflict_cnt_q <= '0;
        end else begin
            conflict_cnt_q <= conflict_cnt_d;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule
